// File: rtl/synapse_array.sv
// Multi-channel windowed synapse: per-channel weight/threshold, saturating
// accumulation over a shared enabled-cycle window, level or single-pulse output.
module synapse_array #(
   parameter int NUM_CH   = 4,
   parameter int WEIGHT_W = 8,
   parameter int ACC_W    = 16,
   parameter int WINDOW   = 48,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                mode,
   input  logic [NUM_CH-1:0]   pre_spike,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WEIGHT_W-1:0] cfg_weight,
   input  logic [WEIGHT_W-1:0] cfg_thresh,
   output logic [NUM_CH-1:0]   weighted_spike,
   output logic [NUM_CH-1:0]   acc_sat,
   output logic                window_done
);

   localparam int CNT_W = $clog2(WINDOW);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

   logic [WEIGHT_W-1:0] weight_q [NUM_CH];
   logic [WEIGHT_W-1:0] weight_d [NUM_CH];
   logic [WEIGHT_W-1:0] thresh_q [NUM_CH];
   logic [WEIGHT_W-1:0] thresh_d [NUM_CH];
   logic [ACC_W-1:0]    acc_q    [NUM_CH];
   logic [ACC_W-1:0]    acc_d    [NUM_CH];
   logic [ACC_W:0]      sum      [NUM_CH];
   logic [ACC_W-1:0]    acc_nx   [NUM_CH];
   logic [NUM_CH-1:0]   hit;
   logic [NUM_CH-1:0]   fired_q, fired_d;
   logic [NUM_CH-1:0]   spike_q, spike_d;
   logic [NUM_CH-1:0]   sat_q, sat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                last;

   always_comb begin
      last    = enable && (cnt_q == LAST);
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      spike_d = '0;
      sat_d   = sat_q;
      fired_d = fired_q;
      hit     = '0;
      if (enable) begin
         cnt_d  = last ? '0 : cnt_q + CNT_W'(1);
         done_d = last;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         weight_d[i] = weight_q[i];
         thresh_d[i] = thresh_q[i];
         acc_d[i]    = acc_q[i];
         // Loop index never reaches an out-of-range cfg_ch, so such writes drop out.
         if (cfg_we && (cfg_ch == CH_W'(i))) begin
            weight_d[i] = cfg_weight;
            thresh_d[i] = cfg_thresh;
         end
         sum[i]    = {1'b0, acc_q[i]} + (pre_spike[i] ? (ACC_W+1)'(weight_q[i]) : '0);
         acc_nx[i] = sum[i][ACC_W] ? '1 : sum[i][ACC_W-1:0];
         hit[i]    = acc_nx[i] > ACC_W'(thresh_q[i]);
         if (enable) begin
            acc_d[i]   = last ? '0 : acc_nx[i];
            spike_d[i] = mode ? (hit[i] & ~fired_q[i]) : hit[i];
            fired_d[i] = last ? 1'b0 : (fired_q[i] | (mode & hit[i]));
            // Saturation in the closing cycle is discarded with the window.
            sat_d[i]   = last ? 1'b0 : (sat_q[i] | sum[i][ACC_W]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            weight_q[i] <= '0;
            thresh_q[i] <= '1;
            acc_q[i]    <= '0;
         end
         fired_q <= '0;
         spike_q <= '0;
         sat_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            weight_q[i] <= weight_d[i];
            thresh_q[i] <= thresh_d[i];
            acc_q[i]    <= acc_d[i];
         end
         fired_q <= fired_d;
         spike_q <= spike_d;
         sat_q   <= sat_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign weighted_spike = spike_q;
   assign acc_sat        = sat_q;
   assign window_done    = done_q;

endmodule

// File: tb/tb_synapse_array.sv
// Directed bench for synapse_array: three channels, 8-bit accumulators,
// 8-cycle window; expected values are hand-computed per step.
module tb_synapse_array;

  localparam int NUM_CH = 3;
  localparam int WW     = 8;
  localparam int AW     = 8;
  localparam int WIN    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic              mode = 1'b0;
  logic [NUM_CH-1:0] pre_spike = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [WW-1:0]     cfg_weight = '0;
  logic [WW-1:0]     cfg_thresh = '0;
  logic [NUM_CH-1:0] weighted_spike;
  logic [NUM_CH-1:0] acc_sat;
  logic              window_done;

  int n_checks = 0;
  int n_fail   = 0;

  synapse_array #(
    .NUM_CH(NUM_CH), .WEIGHT_W(WW), .ACC_W(AW), .WINDOW(WIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .pre_spike(pre_spike), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_weight(cfg_weight), .cfg_thresh(cfg_thresh),
    .weighted_spike(weighted_spike), .acc_sat(acc_sat),
    .window_done(window_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [WW-1:0] w, input logic [WW-1:0] t);
    cfg_we = 1'b1; cfg_ch = ch; cfg_weight = w; cfg_thresh = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] ws, input logic [2:0] sat,
                            input logic done);
    check({tag, ".ws"},   8'(weighted_spike), 8'(ws));
    check({tag, ".sat"},  8'(acc_sat),        8'(sat));
    check({tag, ".done"}, 8'(window_done),    8'(done));
  endtask

  initial begin
    // reset
    #2 rst_n = 1'b0;
    #1 check_outs("reset", 3'b000, 3'b000, 1'b0);
    tick(); tick();
    #3 rst_n = 1'b1;

    // level mode: ch0 w3/t5, ch1 w10/t4, ch2 left at reset (w0)
    cfg_write(2'd0, 8'd3, 8'd5);
    cfg_write(2'd1, 8'd10, 8'd4);
    enable = 1'b1; mode = 1'b0; pre_spike = 3'b011;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < WIN; k++) begin
        tick();
        check_outs($sformatf("level.w%0d.k%0d", w, k), (k == 0) ? 3'b010 : 3'b011, 3'b000, k == WIN-1);
      end
    enable = 1'b0;
    tick();
    check_outs("level.disabled", 3'b000, 3'b000, 1'b0);

    // pulse mode: one pulse per channel per window, re-fires next window
    enable = 1'b1; mode = 1'b1;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < WIN; k++) begin
        tick();
        check_outs($sformatf("pulse.w%0d.k%0d", w, k),
                   (k == 0) ? 3'b010 : (k == 1) ? 3'b001 : 3'b000, 3'b000, k == WIN-1);
      end

    // saturation on ch2: 200 then clamp at 255, never > 255
    enable = 1'b0; mode = 1'b0; pre_spike = 3'b100;
    cfg_write(2'd2, 8'd200, 8'd255);
    enable = 1'b1;
    for (int k = 0; k < WIN; k++) begin
      tick();
      check_outs($sformatf("sat.k%0d", k), 3'b000,
                 (k >= 1 && k <= WIN-2) ? 3'b100 : 3'b000, k == WIN-1);
    end

    // enable gating: only enabled-cycle spikes (ch0) count; ch1 spikes only while disabled
    for (int k = 0; k < WIN; k++) begin
      enable = 1'b1; pre_spike = 3'b001;
      tick();
      check_outs($sformatf("gate.en%0d", k), (k == 0) ? 3'b000 : 3'b001, 3'b000, k == WIN-1);
      enable = 1'b0; pre_spike = 3'b011;
      tick();
      check_outs($sformatf("gate.dis%0d", k), 3'b000, 3'b000, 1'b0);
    end

    // out-of-range channel write must leave every channel untouched
    cfg_write(2'd3, 8'd1, 8'd0);
    enable = 1'b1; pre_spike = 3'b011;
    for (int k = 0; k < WIN; k++) begin
      tick();
      check_outs($sformatf("oor.k%0d", k), (k == 0) ? 3'b010 : 3'b011, 3'b000, k == WIN-1);
    end

    // write ch0 in the same cycle as its spike: old weight 3 used, then 100
    pre_spike = 3'b001;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_weight = 8'd100; cfg_thresh = 8'd50;
    tick();
    cfg_we = 1'b0;
    check_outs("wr_same.k0", 3'b000, 3'b000, 1'b0);
    tick();
    check_outs("wr_same.k1", 3'b001, 3'b000, 1'b0);
    pre_spike = 3'b000;
    for (int k = 2; k < 5; k++) begin
      tick();
      check_outs($sformatf("wr_same.k%0d", k), 3'b001, 3'b000, 1'b0);
    end

    // async reset with counter at 5 and acc0 = 103
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 3'b000, 3'b000, 1'b0);
    tick();
    #3 rst_n = 1'b1;
    pre_spike = 3'b111;
    for (int k = 0; k < WIN; k++) begin
      tick();
      check_outs($sformatf("post_rst.k%0d", k), 3'b000, 3'b000, k == WIN-1);
    end
    tick();
    check_outs("post_rst.next", 3'b000, 3'b000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/synapse_array.md
Name: synapse_array

Overview:
- Multi-channel successor to the single-channel windowed synapse.
- Holds one programmable weight and one threshold per channel.
- Accumulates weighted pre-synaptic spikes over a shared, parametrised spiking window, with saturating arithmetic.
- Emits a per-channel output spike in level or single-pulse mode. Sits between the spike-encoder outputs and the neuron layer.

Parameters:
- NUM_CH, 4, number of independent synapse channels (1..64).
- WEIGHT_W, 8, width of unsigned weight and threshold registers.
- ACC_W, 16, width of the unsigned per-channel accumulator; must be >= WEIGHT_W.
- WINDOW, 48, window length in enabled cycles (>= 2).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  advance window and accumulate when high
- mode  input  1  0 = level output, 1 = pulse output
- pre_spike  input  NUM_CH  incoming spike per channel
- cfg_we  input  1  configuration write strobe
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel for the write
- cfg_weight  input  WEIGHT_W  weight value to write
- cfg_thresh  input  WEIGHT_W  threshold value to write
- weighted_spike  output  NUM_CH  registered output spike per channel
- acc_sat  output  NUM_CH  sticky-per-window flag: the channel accumulator saturated this window
- window_done  output  1  one-cycle pulse on the cycle after the last window cycle

Behaviour:
- Reset, asynchronous: weights=0; thresholds=all ones; accumulators=0; window counter=0; fired flags=0; weighted_spike=0; acc_sat=0; window_done=0.
- Configuration:
  - On cfg_we, the weight and threshold of channel cfg_ch are written; the new values are used from the next cycle.
  - If cfg_ch >= NUM_CH, the write is ignored.
  - Writes are accepted regardless of enable.
  - A write in the same cycle as a spike on that channel uses the old weight.
- Window counter:
  - Runs 0..WINDOW-1 and advances only when enable=1.
  - On an enabled cycle with counter==WINDOW-1: counter wraps to 0 and window_done<=1 (next cycle only).
- Per channel, on an enabled cycle:
  - acc_next = acc + (pre_spike ? weight, zero-extended : 0).
  - If this exceeds 2^ACC_W-1, acc_next = 2^ACC_W-1 and acc_sat<=1.
  - Compare: hit = (acc_next > threshold zero-extended). This is strict greater-than and includes the current cycle's spike.
  - mode=0: weighted_spike <= hit.
  - mode=1: weighted_spike <= hit & ~fired; fired <= fired | hit. This gives at most one pulse per channel per window.
  - Output latency: one cycle from pre_spike to weighted_spike.
- Window end (enabled cycle with counter==WINDOW-1):
  - The output is still computed from that cycle's acc_next.
  - Then acc<=0, fired<=0, and acc_sat<=0 (saturation in the final cycle is not reported).
- enable=0: counter, accumulators, fired and acc_sat hold; weighted_spike<=0; window_done<=0; pre_spike is ignored.
- A mode change mid-window takes effect on the next enabled cycle; fired flags are not cleared by a mode change.
- Channels are fully independent; all channels share one window counter.
- Reset mid-window aborts the window: all state returns to reset values immediately.
- Expected RTL size: 150-250 lines.

Test Plan:
- Defaults, WINDOW=8: reset, then write ch0 weight=3/thresh=5 and ch1 weight=10/thresh=4. Hold pre_spike=2'b11 with enable=1. Required: ch1 spike from cycle 1 after the first enabled cycle; ch0 first spike on the 2nd enabled spike cycle (acc 6>5). In mode=0 both stay high through cycle 7. window_done pulses once every 8 enabled cycles.
- Pulse mode: same configuration with mode=1. Required: exactly one weighted_spike pulse per channel per window; the first cycle of the next window re-fires after accumulators clear.
- Saturation: ACC_W=8, weight=200, thresh=255, spike every cycle. Required: acc clamps at 255 on the 2nd spike, acc_sat=1, no output spike (255 is not >255), and acc_sat clears at the window boundary.
- Enable gating: toggle enable 1/0 each cycle, WINDOW=8. Required: window_done every 16 clocks; weighted_spike=0 on every disabled cycle; spikes presented on disabled cycles are not counted.
- Config edge cases:
  - Write cfg_ch=NUM_CH. Required: no register changes.
  - Write ch0 weight in the same cycle as a spike. Required: the old weight is accumulated and the new weight is used from the next spike.
- Async reset mid-window at counter=5 with nonzero accumulators. Required: all outputs drop to 0 without a clock edge; after release the first window_done appears after exactly WINDOW enabled cycles; weights/thresholds are back to 0/all ones.
